// File: rtl/rbm_cd_update_if.sv
// rbm_cd_update_if: handshake and memory bus of the CD-1 update stage.
//   master : upstream/memory side (drives start, samples, mem_rdata)
//   slave  : rbm_cd_update (drives memory address/data/strobe, busy, done)
// Signals:
//   start                : request one update pass
//   V0I/H0I/V1I/H1I      : packed sample vectors, element nonzero = 1
//   mem_addr/mem_we      : weight/bias memory address and write strobe
//   mem_wdata/mem_rdata  : write data / read data (read valid one cycle after addr)
//   busy/done            : pass in progress / single-cycle completion pulse
interface rbm_cd_update_if #(
    parameter int weight_bitlength = 12,
    parameter int sample_bitlength = 12,
    parameter int in_dim           = 6,
    parameter int out_dim          = 5,
    parameter int addr_bitlength   = 6
);
    logic                                 start;
    logic [in_dim*sample_bitlength-1:0]   V0I;
    logic [out_dim*sample_bitlength-1:0]  H0I;
    logic [in_dim*sample_bitlength-1:0]   V1I;
    logic [out_dim*sample_bitlength-1:0]  H1I;
    logic [addr_bitlength-1:0]            mem_addr;
    logic [weight_bitlength-1:0]          mem_rdata;
    logic [weight_bitlength-1:0]          mem_wdata;
    logic                                 mem_we;
    logic                                 busy;
    logic                                 done;

    modport master (
        output start, V0I, H0I, V1I, H1I, mem_rdata,
        input  mem_addr, mem_wdata, mem_we, busy, done
    );

    modport slave (
        input  start, V0I, H0I, V1I, H1I, mem_rdata,
        output mem_addr, mem_wdata, mem_we, busy, done
    );
endinterface

// File: rtl/rbm_cd_update.sv
// rbm_cd_update: CD-1 weight/bias update by sequential read-modify-write.
//   W[i][j] += lr_step*(v0[i]h0[j] - v1[i]h1[j]) at address i*out_dim+j
//   b[j]    += lr_step*(h0[j] - h1[j])            at address in_dim*out_dim+j
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : rbm_cd_update_if.slave (start, samples, memory bus, busy, done)
// Optional build macro CD_SKIP_ZERO_EN: entries whose delta is zero are
// skipped; a SCAN state jumps straight to the next nonzero-delta entry.
module rbm_cd_update #(
    parameter int weight_bitlength = 12,
    parameter int sample_bitlength = 12,
    parameter int in_dim           = 6,
    parameter int out_dim          = 5,
    parameter int addr_bitlength   = 6,
    parameter int lr_step          = 1
) (
    input  logic           clock,
    input  logic           reset,
    rbm_cd_update_if.slave bus
);
    localparam int W  = weight_bitlength;
    localparam int IW = $clog2(in_dim + 1);
    localparam int JW = (out_dim > 1) ? $clog2(out_dim) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(in_dim);
    localparam logic [JW-1:0] J_LAST = JW'(out_dim - 1);
    localparam logic signed [W:0] STEP  = (W+1)'(lr_step);
    localparam logic signed [W:0] MAX_V = (W+1)'((1 << (W-1)) - 1);
    localparam logic signed [W:0] MIN_V = (W+1)'(-(1 << (W-1)));

    typedef enum logic [2:0] {IDLE, RD, WR, FIN, SCAN} state_t;

    state_t                    state;
    logic [IW-1:0]             i_cnt;
    logic [JW-1:0]             j_cnt;
    logic [addr_bitlength-1:0] addr_q;
    logic                      we_q, busy_q, done_q;
    logic [in_dim-1:0]         v0_q, v1_q, v0_b, v1_b;
    logic [out_dim-1:0]        h0_q, h1_q, h0_b, h1_b;
    logic [in_dim:0]           v0_x, v1_x;
    logic                      p, q;
    logic signed [W:0]         r_ext, sum_ext, sat_ext;

    // Bias row is visible unit in_dim with v0=v1=1.
    assign v0_x = {1'b1, v0_q};
    assign v1_x = {1'b1, v1_q};

    always_comb begin
        v0_b = '0;
        v1_b = '0;
        h0_b = '0;
        h1_b = '0;
        for (int k = 0; k < in_dim; k++) begin
            v0_b[k] = |bus.V0I[k*sample_bitlength +: sample_bitlength];
            v1_b[k] = |bus.V1I[k*sample_bitlength +: sample_bitlength];
        end
        for (int k = 0; k < out_dim; k++) begin
            h0_b[k] = |bus.H0I[k*sample_bitlength +: sample_bitlength];
            h1_b[k] = |bus.H1I[k*sample_bitlength +: sample_bitlength];
        end
    end

    assign p = v0_x[i_cnt] & h0_q[j_cnt];
    assign q = v1_x[i_cnt] & h1_q[j_cnt];

    // One extra bit of headroom so the sum cannot wrap before clamping.
    always_comb begin
        r_ext = $signed({bus.mem_rdata[W-1], bus.mem_rdata});
        case ({p, q})
            2'b10:   sum_ext = r_ext + STEP;
            2'b01:   sum_ext = r_ext - STEP;
            default: sum_ext = r_ext;
        endcase
        if (sum_ext > MAX_V)      sat_ext = MAX_V;
        else if (sum_ext < MIN_V) sat_ext = MIN_V;
        else                      sat_ext = sum_ext;
    end

`ifdef CD_SKIP_ZERO_EN
    // Lowest entry at or after addr_q with a nonzero delta.
    logic                      nz_found;
    logic [addr_bitlength-1:0] nz_addr;
    logic [IW-1:0]             nz_i;
    logic [JW-1:0]             nz_j;

    always_comb begin
        nz_found = 1'b0;
        nz_addr  = '0;
        nz_i     = '0;
        nz_j     = '0;
        for (int k = (in_dim+1)*out_dim - 1; k >= 0; k--) begin
            if (k >= int'(addr_q) &&
                ((v0_x[IW'(k / out_dim)] & h0_q[JW'(k % out_dim)]) !=
                 (v1_x[IW'(k / out_dim)] & h1_q[JW'(k % out_dim)]))) begin
                nz_found = 1'b1;
                nz_addr  = addr_bitlength'(k);
                nz_i     = IW'(k / out_dim);
                nz_j     = JW'(k % out_dim);
            end
        end
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            i_cnt  <= '0;
            j_cnt  <= '0;
            addr_q <= '0;
            we_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            v0_q   <= '0;
            v1_q   <= '0;
            h0_q   <= '0;
            h1_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    we_q   <= 1'b0;
                    if (bus.start) begin
                        v0_q   <= v0_b;
                        v1_q   <= v1_b;
                        h0_q   <= h0_b;
                        h1_q   <= h1_b;
                        i_cnt  <= '0;
                        j_cnt  <= '0;
                        addr_q <= '0;
                        busy_q <= 1'b1;
`ifdef CD_SKIP_ZERO_EN
                        state  <= SCAN;
`else
                        state  <= RD;
`endif
                    end
                end
`ifdef CD_SKIP_ZERO_EN
                SCAN: begin
                    if (nz_found) begin
                        i_cnt  <= nz_i;
                        j_cnt  <= nz_j;
                        addr_q <= nz_addr;
                        state  <= RD;
                    end else begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= FIN;
                    end
                end
`endif
                RD: begin
                    we_q  <= 1'b1;
                    state <= WR;
                end
                WR: begin
                    we_q <= 1'b0;
                    if (i_cnt == I_LAST && j_cnt == J_LAST) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= FIN;
                    end else begin
                        // Address order equals (i,j) order with j fastest.
                        addr_q <= addr_q + 1'b1;
                        if (j_cnt == J_LAST) begin
                            j_cnt <= '0;
                            i_cnt <= i_cnt + 1'b1;
                        end else begin
                            j_cnt <= j_cnt + 1'b1;
                        end
`ifdef CD_SKIP_ZERO_EN
                        state <= SCAN;
`else
                        state <= RD;
`endif
                    end
                end
                FIN: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_we    = we_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    // Read data only exists during WR, so the write data follows it directly.
    assign bus.mem_wdata = (state == WR) ? sat_ext[W-1:0] : '0;
endmodule

// File: tb/tb_rbm_cd_update.sv
module tb_rbm_cd_update;
    localparam int WB  = 12;
    localparam int SB  = 12;
    localparam int ID  = 6;
    localparam int OD  = 5;
    localparam int AB  = 6;
    localparam int ENT = (ID + 1) * OD;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    rbm_cd_update_if #(.weight_bitlength(WB), .sample_bitlength(SB), .in_dim(ID),
                       .out_dim(OD), .addr_bitlength(AB)) bus ();

    rbm_cd_update #(.weight_bitlength(WB), .sample_bitlength(SB), .in_dim(ID),
                    .out_dim(OD), .addr_bitlength(AB), .lr_step(1))
        dut (.clock(clock), .reset(reset), .bus(bus));

    // Memory: registered read, write on strobe.
    logic [WB-1:0] mem [0:(1<<AB)-1];
    always @(posedge clock) begin
        bus.mem_rdata <= mem[bus.mem_addr];
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int ref_mem [ENT];
    bit rv0 [ID];
    bit rv1 [ID];
    bit rh0 [OD];
    bit rh1 [OD];

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int elem(input int mode_bit);
        if (mode_bit != 0) return int'($urandom_range(1, (1 << SB) - 1));
        return 0;
    endfunction

    // mode 0: all zero; 1: v0,h0 ones; 2: v1,h1 ones; 3: random.
    task automatic load_vecs(input int mode);
        int b;
        for (int k = 0; k < ID; k++) begin
            b = (mode == 1) ? 1 : (mode == 3) ? int'($urandom_range(0, 1)) : 0;
            rv0[k] = (b != 0);
            bus.V0I[k*SB +: SB] = SB'(elem(b));
            b = (mode == 2) ? 1 : (mode == 3) ? int'($urandom_range(0, 1)) : 0;
            rv1[k] = (b != 0);
            bus.V1I[k*SB +: SB] = SB'(elem(b));
        end
        for (int k = 0; k < OD; k++) begin
            b = (mode == 1) ? 1 : (mode == 3) ? int'($urandom_range(0, 1)) : 0;
            rh0[k] = (b != 0);
            bus.H0I[k*SB +: SB] = SB'(elem(b));
            b = (mode == 2) ? 1 : (mode == 3) ? int'($urandom_range(0, 1)) : 0;
            rh1[k] = (b != 0);
            bus.H1I[k*SB +: SB] = SB'(elem(b));
        end
    endtask

    // rnd=0: every word = val; rnd=1: mix of extremes and random values.
    task automatic fill_mem(input bit rnd, input int val);
        int v;
        for (int k = 0; k < ENT; k++) begin
            v = val;
            if (rnd) begin
                case ($urandom_range(0, 4))
                    0:       v = 2047;
                    1:       v = -2048;
                    2:       v = 0;
                    default: v = int'($urandom_range(0, 4095)) - 2048;
                endcase
            end
            mem[k]     = WB'(v);
            ref_mem[k] = v;
        end
    endtask

    // Reference update for entry k straight from the learning rule.
    function automatic int ref_upd(input int k, input int old);
        int i, j, a, b, r;
        i = k / OD;
        j = k % OD;
        a = (i < ID) ? int'(rv0[i]) : 1;
        b = (i < ID) ? int'(rv1[i]) : 1;
        r = old + a * int'(rh0[j]) - b * int'(rh1[j]);
        if (r > 2047)  r = 2047;
        if (r < -2048) r = -2048;
        return r;
    endfunction

    task automatic check_mem(input string tag);
        for (int k = 0; k < ENT; k++)
            chk($sformatf("%s_w%0d", tag, k), int'($signed(mem[k])), ref_mem[k]);
    endtask

    // One pass. poke: re-assert start and change V0I mid-pass.
    // rst_at > 0: assert reset in that cycle and abandon the pass.
    task automatic run_pass(input string tag, input bit poke, input int rst_at);
        int busy_n, wr_n, done_c;
        busy_n = 0;
        wr_n   = 0;
        done_c = -1;
        @(negedge clock);
        bus.start = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clock);
            if (c == 1) begin
                bus.start = 1'b0;
                chk({tag, "_rd_addr0"}, int'(bus.mem_addr), 0);
                chk({tag, "_rd_we"}, int'(bus.mem_we), 0);
            end
            if (c == 2) chk({tag, "_wr_we"}, int'(bus.mem_we), 1);
            if (poke && c == 10) begin
                bus.start = 1'b1;
                bus.V0I   = ~bus.V0I;
            end
            if (poke && c == 11) bus.start = 1'b0;
            if (c == rst_at) begin
                reset = 1'b1;
                #1;
                chk({tag, "_rst_we"}, int'(bus.mem_we), 0);
                chk({tag, "_rst_busy"}, int'(bus.busy), 0);
                chk({tag, "_rst_done"}, int'(bus.done), 0);
                chk({tag, "_rst_addr"}, int'(bus.mem_addr), 0);
                @(negedge clock);
                chk({tag, "_rst_nodone"}, int'(bus.done), 0);
                reset = 1'b0;
                return;
            end
            busy_n += int'(bus.busy);
            wr_n   += int'(bus.mem_we);
            if (bus.done) begin
                done_c = c;
                break;
            end
        end
        if (done_c < 0) begin
            chk({tag, "_done_timeout"}, 0, 1);
            return;
        end
        chk({tag, "_done_cycle"}, done_c, 2 * ENT + 1);
        chk({tag, "_busy_cycles"}, busy_n, 2 * ENT);
        chk({tag, "_writes"}, wr_n, ENT);
        chk({tag, "_fin_busy"}, int'(bus.busy), 0);
        @(negedge clock);
        chk({tag, "_done_pulse"}, int'(bus.done), 0);
        for (int k = 0; k < ENT; k++) ref_mem[k] = ref_upd(k, ref_mem[k]);
        check_mem(tag);
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        load_vecs(0);
        fill_mem(1'b0, 0);
        repeat (2) @(negedge clock);
        chk("rst_addr", int'(bus.mem_addr), 0);
        chk("rst_wdata", int'(bus.mem_wdata), 0);
        chk("rst_we", int'(bus.mem_we), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        reset = 1'b0;

        // Zero samples: every word written back unchanged.
        load_vecs(0); fill_mem(1'b0, 5);     run_pass("zero", 1'b0, 0);
        load_vecs(1); fill_mem(1'b0, 0);     run_pass("pos", 1'b0, 0);
        load_vecs(2); fill_mem(1'b0, 0);     run_pass("neg", 1'b0, 0);
        load_vecs(1); fill_mem(1'b0, 2047);  run_pass("sat_hi", 1'b0, 0);
        load_vecs(2); fill_mem(1'b0, -2048); run_pass("sat_lo", 1'b0, 0);

        for (int t = 0; t < 4; t++) begin
            load_vecs(3);
            fill_mem(1'b1, 0);
            run_pass($sformatf("rnd%0d", t), 1'b0, 0);
        end

        // Restart and input change mid-pass must not disturb the pass.
        load_vecs(3); fill_mem(1'b1, 0); run_pass("poke", 1'b1, 0);

        // Reset in cycle 20: WR cycles 2..18 completed, i.e. entries 0..8.
        load_vecs(3); fill_mem(1'b1, 0);
        run_pass("midrst", 1'b0, 20);
        for (int k = 0; k < 9; k++) ref_mem[k] = ref_upd(k, ref_mem[k]);
        check_mem("midrst_keep");
        load_vecs(3);
        run_pass("after_rst", 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
